// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-client round-robin arbiter for one port of the 16x8 dual-port RAM
//
// Time-shares a single RAM port between two clients. Each client issues one
// read or write per req/done handshake. Writes take WR then ACK. Reads take
// RD1 (RAM loads its read register), RD2 (RAM drives the bus, result captured)
// and then ACK. Every output is a register, so nothing on the client side
// reaches the RAM pins or the gnt/done outputs in the same cycle.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_x, we_x, addr_x,       client x request, direction, address, write data
//   wdata_x                    (held stable while req_x is high)
//   gnt_x                      client x owns the port (grant edge .. end of ACK)
//   done_x                     one-cycle completion pulse (ACK state)
//   rdata                      last read result, valid from the done of a read
//   ram_cs, ram_wr_en,         RAM port control pins
//   ram_out_en, ram_addr
//   ram_data                   shared RAM data bus, driven here only during WR

module ram_port_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_0,
  input  logic              req_1,
  input  logic              we_0,
  input  logic              we_1,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_0,
  input  logic [DATA_W-1:0] wdata_1,
  output logic              gnt_0,
  output logic              gnt_1,
  output logic              done_0,
  output logic              done_1,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_cs,
  output logic              ram_wr_en,
  output logic              ram_out_en,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD1,
    S_RD2,
    S_ACK
  } state_t;

  state_t            state;
  logic              owner;    // client holding the current grant
  logic              prio;     // client that wins the next tie
  logic [DATA_W-1:0] wdata_q;

  logic              winner;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  // Winner select: the pointer only matters when both clients are asking;
  // with a single request the requester wins (~req_0 picks client 1 when
  // only req_1 is high).
  always_comb begin
    winner    = (req_0 && req_1) ? prio : ~req_0;
    win_we    = winner ? we_1    : we_0;
    win_addr  = winner ? addr_1  : addr_0;
    win_wdata = winner ? wdata_1 : wdata_0;
  end

  // The write enable doubles as the bus-drive enable, so the arbiter can only
  // drive ram_data in WR, and never while the RAM has ram_out_en asserted.
  assign ram_data = ram_wr_en ? wdata_q : {DATA_W{1'bz}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      prio       <= 1'b0;
      wdata_q    <= '0;
      gnt_0      <= 1'b0;
      gnt_1      <= 1'b0;
      done_0     <= 1'b0;
      done_1     <= 1'b0;
      rdata      <= '0;
      ram_cs     <= 1'b0;
      ram_wr_en  <= 1'b0;
      ram_out_en <= 1'b0;
      ram_addr   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_0 || req_1) begin
            owner     <= winner;
            prio      <= ~winner;
            gnt_0     <= ~winner;
            gnt_1     <= winner;
            wdata_q   <= win_wdata;
            ram_cs    <= 1'b1;
            ram_wr_en <= win_we;
            ram_addr  <= win_addr;
            state     <= win_we ? S_WR : S_RD1;
          end
        end
        S_WR: begin
          ram_cs    <= 1'b0;
          ram_wr_en <= 1'b0;
          ram_addr  <= '0;
          done_0    <= ~owner;
          done_1    <= owner;
          state     <= S_ACK;
        end
        S_RD1: begin
          // RAM read register loads at this edge; open its output for RD2.
          ram_out_en <= 1'b1;
          state      <= S_RD2;
        end
        S_RD2: begin
          rdata      <= ram_data;
          ram_cs     <= 1'b0;
          ram_out_en <= 1'b0;
          ram_addr   <= '0;
          done_0     <= ~owner;
          done_1     <= owner;
          state      <= S_ACK;
        end
        S_ACK: begin
          done_0 <= 1'b0;
          done_1 <= 1'b0;
          gnt_0  <= 1'b0;
          gnt_1  <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester round-robin arbiter that time-shares one port of the team's 16x8 dual-port RAM (cs / wr_en / out_en / 4-bit address / bidirectional 8-bit data, registered read). Each requester presents a single read or write with a req/done handshake. The arbiter sequences the RAM port control pins, including the two-cycle registered-read protocol, and returns read data. It sits between the RAM port and two client blocks.

## Interface
- ADDR_W, 4, RAM address width
- DATA_W, 8, RAM data width
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_0 / req_1  in  1  request from client 0 / 1; held until matching done
- we_0 / we_1  in  1  1 = write, 0 = read; stable while req high
- addr_0 / addr_1  in  ADDR_W  target address; stable while req high
- wdata_0 / wdata_1  in  DATA_W  write data; stable while req high
- gnt_0 / gnt_1  out  1  client owns the RAM port; at most one high
- done_0 / done_1  out  1  one-cycle completion pulse
- rdata  out  DATA_W  read result; valid in the done cycle of a read; holds until next read
- ram_cs  out  1  RAM chip select
- ram_wr_en  out  1  RAM write enable
- ram_out_en  out  1  RAM output enable
- ram_addr  out  ADDR_W  RAM address
- ram_data  inout  DATA_W  RAM data bus; driven by arbiter only in WR, else high-Z

## Operation
- FSM states: IDLE, WR, RD1, RD2, ACK.
- IDLE:
  - Sample req_0/req_1.
  - One request pending: grant it. Both pending: grant the client indicated by priority pointer prio.
  - On grant, latch we/addr/wdata of the winner and set gnt_x.
  - Next state is WR if we = 1, else RD1.
  - prio <= loser. It toggles only when both requests were pending; on a lone grant it is set to the other client.
- WR: ram_cs=1, ram_wr_en=1, ram_out_en=0, ram_addr=latched addr, ram_data=latched wdata. Next: ACK.
- RD1: ram_cs=1, ram_wr_en=0, ram_out_en=0, ram_addr=latched addr. The RAM loads its read register at the end of RD1. Next: RD2.
- RD2: ram_cs=1, ram_wr_en=0, ram_out_en=1, same addr. The RAM drives ram_data; rdata <= ram_data at the end of RD2. Next: ACK.
- ACK: all RAM controls 0. done_x=1 for the granted client. gnt_x clears at the end of ACK. Next: IDLE.
- RAM pins, gnt and done are decoded only from the state register and latched registers. No combinational path from req/we/addr/wdata to any output.
- Bus rule: the arbiter drives ram_data only while ram_wr_en=1. ram_out_en is never 1 in the same cycle as ram_wr_en.
- Client deasserting req before done: the transaction still completes and done still pulses.
- Client still holding req after done: treated as a new request in IDLE, subject to round-robin.
- Reset values: state=IDLE, prio=client 0, gnt_0=gnt_1=0, done_0=done_1=0, rdata=0, ram_cs=ram_wr_en=ram_out_en=0, ram_addr=0, ram_data=high-Z.
- Reset mid-transaction: immediately abandons the operation and returns all outputs to reset values. No done is issued. A write in WR before the edge may or may not have landed.

## Timing
- Request visible before edge E0 in IDLE → gnt_x high after E0.
- Write: WR in E0–E1 (memory updated at E1). ACK/done in E1–E2. IDLE from E2. Write throughput is 1 per 3 cycles.
- Read: RD1 in E0–E1, RD2 in E1–E2, ACK in E2–E3 with rdata valid. IDLE from E3. Read throughput is 1 per 4 cycles.
- gnt_x stays high from E0 until the end of ACK inclusive.
- Grants are issued only in IDLE. There is no back-to-back grant without an IDLE cycle between.
- A request arriving while the port is busy waits; it is not dropped.

## Test plan
- Reset: hold rst_n=0 with random req → all outputs at reset values, ram_data=Z. Release → first grant appears only after req is sampled in IDLE.
- Single write then read: client 0 writes 8'hA5 to addr 4'h3; then client 0 reads addr 3.
  - Write: done_0 two cycles after grant, RAM location 3 = A5.
  - Read: ram_out_en high only in RD2; done_0 three cycles after grant with rdata=8'hA5.
- Contention: req_0 and req_1 rise together (both writes: 0→addr1=8'h11, 1→addr2=8'h22) → client 0 served first (prio reset). Client 1 granted in the next IDLE. Both locations correct. gnt_0 and gnt_1 never high together.
- Fairness: both clients hold req continuously for 8 transactions → grants strictly alternate 0,1,0,1…. ram_wr_en and ram_out_en are never both 1. ram_data is driven only in WR.
- Abort: assert rst_n=0 during RD2 of a client 1 read → outputs go to reset values asynchronously. No done_1 pulse. rdata=0.
- Early drop: client 1 read of addr F (preloaded 8'h5C), req_1 dropped during RD1 → transaction completes, done_1 pulses, rdata=8'h5C. No further grant is issued to client 1.
